// File: rtl/full_adder_pkg.sv
// full_adder_pkg: shared constants and result type for the ripple-carry adder
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;
    localparam int FA_MAX_WIDTH = 64;

    typedef struct packed {
        logic co;
        logic [FA_MAX_WIDTH-1:0] sum;
    } fa_result_t;

endpackage

// File: rtl/full_adder_bit.sv
// fa_bit: combinational one-bit full-adder cell
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);

    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder.sv
// full_adder: WIDTH-bit ripple-carry adder with one registered output stage
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        fa_bit u_bit (
            .a  (a[i]),
            .b  (b[i]),
            .cin(c[i]),
            .s  (s[i]),
            .c  (c[i+1])
        );
    end

    // capture only qualified operands so idle-cycle garbage never reaches the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            co        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum <= s;
                co  <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench driving a 1-bit and an 8-bit adder in lockstep
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst, in_valid, cin;
    logic [7:0] a8, b8;
    logic       out_valid1, sum1, co1;
    logic       out_valid8, co8;
    logic [7:0] sum8;

    int tests = 0;
    int fails = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic       exp_v = 1'b0;
    logic [8:0] hold8 = '0;
    logic [1:0] hold1 = '0;
    logic       started = 1'b0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8[0]), .b(b8[0]), .cin(cin),
        .out_valid(out_valid1), .sum(sum1), .co(co1)
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin),
        .out_valid(out_valid8), .sum(sum8), .co(co8)
    );

    task automatic chk(input string n, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // drive one cycle, then record what the registers should hold after the edge
    task automatic step(input logic r, input logic v, input logic [7:0] aa, input logic [7:0] bb, input logic ci);
        rst = r;
        in_valid = v;
        a8 = aa;
        b8 = bb;
        cin = ci;
        @(posedge clk);
        started = 1'b1;
        if (r) begin
            exp_v = 1'b0;
            hold8 = '0;
            hold1 = '0;
        end else if (v) begin
            exp_v = 1'b1;
            hold8 = {1'b0, aa} + {1'b0, bb} + {8'd0, ci};
            hold1 = {1'b0, aa[0]} + {1'b0, bb[0]} + {1'b0, ci};
            q8.push_back(hold8);
            q1.push_back(hold1);
        end else begin
            exp_v = 1'b0;
        end
        #1;
    endtask

    // monitor: pop a result whenever a DUT presents one, else expect the held value
    always @(negedge clk) begin
        if (started) begin
            chk("valid8", {8'd0, out_valid8}, {8'd0, exp_v});
            chk("valid1", {8'd0, out_valid1}, {8'd0, exp_v});
            if (out_valid8) begin
                if (q8.size() == 0) chk("q8_underflow", 9'd1, 9'd0);
                else chk("res8", {co8, sum8}, q8.pop_front());
            end else begin
                chk("hold8", {co8, sum8}, hold8);
            end
            if (out_valid1) begin
                if (q1.size() == 0) chk("q1_underflow", 9'd1, 9'd0);
                else chk("res1", {7'd0, co1, sum1}, {7'd0, q1.pop_front()});
            end else begin
                chk("hold1", {7'd0, co1, sum1}, {7'd0, hold1});
            end
        end
    end

    logic [1:0] tab1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_state", {6'd0, out_valid8, co8, |sum8}, 9'd0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, {7'd0, i[2]}, {7'd0, i[1]}, i[0]);
            chk("w1_table", {7'd0, co1, sum1}, {7'd0, tab1[i]});
        end
        step(1, 1, 1, 1, 1);
        chk("rst_hold_a", {7'd0, out_valid1, co1 | sum1}, 9'd0);
        step(1, 1, 1, 1, 1);
        chk("rst_hold_b", {7'd0, out_valid1, co1 | sum1}, 9'd0);
        step(0, 1, 1, 1, 1);
        chk("rst_release", {6'd0, out_valid1, co1, sum1}, 9'b111);
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 1);
        chk("hold_rule", {6'd0, out_valid1, co1, sum1}, 9'b001);
        step(0, 0, 8'bx, 8'bx, 1'bx);
        chk("x_idle", {co8, sum8}, 9'h001);
        step(0, 1, 8'hFF, 8'h00, 1);
        chk("ripple", {co8, sum8}, 9'h100);
        step(0, 1, 8'hFF, 8'hFF, 1);
        chk("all_ones", {co8, sum8}, 9'h1FF);
        step(0, 1, 8'h00, 8'h00, 0);
        chk("zeros", {co8, sum8}, 9'h000);
        step(0, 1, 8'h03, 8'h04, 0);
        chk("mid_first", {co8, sum8}, 9'h007);
        step(1, 1, 8'h55, 8'h55, 0);
        chk("mid_rst", {out_valid8, sum8}, 9'h000);
        step(0, 1, 8'h81, 8'h82, 1);
        chk("mid_second", {co8, sum8}, 9'h104);
        for (int i = 0; i < 1000; i++)
            step(0, $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("q8_drained", 9'(q8.size()), 9'd0);
        chk("q1_drained", 9'(q1.size()), 9'd0);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
